// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one 4-bit ALU with a single operation in flight.
// Define ALU_ARB_FIXED_PRIORITY_EN for fixed priority (requester 0 first) instead of round-robin.

module alu (
   input  logic [2:0] i_op,
   input  logic [3:0] i_x,
   input  logic [3:0] i_y,
   output logic [3:0] o_s_c,
   output logic       o_c_c,
   output logic       o_zero_c,
   output logic       o_ovf_c
);
   localparam int unsigned W = 4;

   logic         w_cin;
   logic         w_arith;
   logic         w_ovf;
   logic [W-1:0] w_yb;
   logic [W:0]   w_sum;

   // Sub, less-than and equal all reuse the adder as X + ~Y + 1.
   always_comb begin
      w_cin   = (i_op == 3'b001) || (i_op == 3'b110) || (i_op == 3'b111);
      w_yb    = w_cin ? ~i_y : i_y;
      w_sum   = (W+1)'(i_x) + (W+1)'(w_yb) + (W+1)'(w_cin);
      w_ovf   = (i_x[W-1] == w_yb[W-1]) && (w_sum[W-1] != i_x[W-1]);
      w_arith = 1'b0;
      o_s_c   = '0;
      case (i_op)
         3'b000, 3'b001: begin
            o_s_c   = w_sum[W-1:0];
            w_arith = 1'b1;
         end
         3'b010: o_s_c = ~i_x;
         3'b011: o_s_c = i_x & i_y;
         3'b100: o_s_c = i_x | i_y;
         3'b101: o_s_c = i_x ^ i_y;
         3'b110: begin
            o_s_c   = {3'b000, w_sum[W-1] ^ w_ovf};
            w_arith = 1'b1;
         end
         default: begin
            o_s_c   = {3'b000, (w_sum[W-1:0] == 4'h0)};
            w_arith = 1'b1;
         end
      endcase
      o_c_c    = w_arith & w_sum[W];
      o_ovf_c  = w_arith & w_ovf;
      o_zero_c = (o_s_c == 4'h0);
   end
endmodule

module alu_arbiter (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_valid,
   output logic [1:0] req_ready,
   input  logic [5:0] req_op,
   input  logic [7:0] req_x,
   input  logic [7:0] req_y,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic       rsp_id,
   output logic [3:0] rsp_s,
   output logic       rsp_c,
   output logic       rsp_zero,
   output logic       rsp_overflow
);
   localparam int unsigned W   = 4;
   localparam int unsigned OPW = 3;

   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] EXEC = 2'b01;
   localparam logic [1:0] RESP = 2'b10;

   logic [1:0]     r_state;
   logic [1:0]     w_state_nxt;
   logic           w_gnt;
   logic [1:0]     w_ready;
   logic           w_xfer;

   logic [OPW-1:0] r_op;
   logic [W-1:0]   r_x;
   logic [W-1:0]   r_y;
   logic           r_id;

   logic [W-1:0]   w_alu_s;
   logic           w_alu_c;
   logic           w_alu_zero;
   logic           w_alu_ovf;

   logic           r_rsp_id;
   logic [W-1:0]   r_rsp_s;
   logic           r_rsp_c;
   logic           r_rsp_zero;
   logic           r_rsp_ovf;

`ifdef ALU_ARB_FIXED_PRIORITY_EN
   assign w_gnt = ~req_valid[0];
`else
   logic r_last;

   // Under contention the requester not granted last wins.
   assign w_gnt = (&req_valid) ? ~r_last : req_valid[1];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_last <= 1'b1;
      end else if (w_xfer) begin
         r_last <= w_gnt;
      end
   end
`endif

   assign w_ready   = ((r_state == IDLE) && (|req_valid)) ? (w_gnt ? 2'b10 : 2'b01) : 2'b00;
   assign w_xfer    = |(req_valid & w_ready);
   assign req_ready = w_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_xfer) w_state_nxt = EXEC;
         EXEC:    w_state_nxt = RESP;
         RESP:    if (rsp_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   alu u_alu (
      .i_op     (r_op),
      .i_x      (r_x),
      .i_y      (r_y),
      .o_s_c    (w_alu_s),
      .o_c_c    (w_alu_c),
      .o_zero_c (w_alu_zero),
      .o_ovf_c  (w_alu_ovf)
   );

   // Operands latched on transfer; results latched leaving EXEC and held through RESP.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_op       <= '0;
         r_x        <= '0;
         r_y        <= '0;
         r_id       <= 1'b0;
         r_rsp_id   <= 1'b0;
         r_rsp_s    <= '0;
         r_rsp_c    <= 1'b0;
         r_rsp_zero <= 1'b0;
         r_rsp_ovf  <= 1'b0;
      end else begin
         if (w_xfer) begin
            r_op <= w_gnt ? req_op[5:3] : req_op[2:0];
            r_x  <= w_gnt ? req_x[7:4]  : req_x[3:0];
            r_y  <= w_gnt ? req_y[7:4]  : req_y[3:0];
            r_id <= w_gnt;
         end
         if (r_state == EXEC) begin
            r_rsp_id   <= r_id;
            r_rsp_s    <= w_alu_s;
            r_rsp_c    <= w_alu_c;
            r_rsp_zero <= w_alu_zero;
            r_rsp_ovf  <= w_alu_ovf;
         end
      end
   end

   assign rsp_valid    = (r_state == RESP);
   assign rsp_id       = r_rsp_id;
   assign rsp_s        = r_rsp_s;
   assign rsp_c        = r_rsp_c;
   assign rsp_zero     = r_rsp_zero;
   assign rsp_overflow = r_rsp_ovf;
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: scoreboard of expected responses plus directed scenarios.
// Honours ALU_ARB_FIXED_PRIORITY_EN for the expected grant order.

module tb_alu_arbiter;
   typedef struct packed {
      logic       id;
      logic [3:0] s;
      logic       c;
      logic       z;
      logic       v;
   } rsp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] req_valid;
   logic [1:0] req_ready;
   logic [5:0] req_op;
   logic [7:0] req_x;
   logic [7:0] req_y;
   logic       rsp_valid;
   logic       rsp_ready;
   logic       rsp_id;
   logic [3:0] rsp_s;
   logic       rsp_c;
   logic       rsp_zero;
   logic       rsp_overflow;

   int   n_vec = 0;
   int   n_err = 0;
   rsp_t sb[$];
   logic m_last = 1'b1;

   always #5 clk = ~clk;

   alu_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op       (req_op),
      .req_x        (req_x),
      .req_y        (req_y),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_id       (rsp_id),
      .rsp_s        (rsp_s),
      .rsp_c        (rsp_c),
      .rsp_zero     (rsp_zero),
      .rsp_overflow (rsp_overflow)
   );

   // Reference ALU from plain integer arithmetic.
   function automatic rsp_t model(input logic id, input logic [2:0] op, input logic [3:0] x, input logic [3:0] y);
      rsp_t       r;
      int         sx;
      int         sy;
      int         a;
      logic [4:0] f;
      sx   = (x > 4'd7) ? int'(x) - 16 : int'(x);
      sy   = (y > 4'd7) ? int'(y) - 16 : int'(y);
      r    = '0;
      r.id = id;
      case (op)
         3'd0: begin
            f   = {1'b0, x} + {1'b0, y};
            r.s = f[3:0];
            r.c = f[4];
            a   = sx + sy;
            r.v = (a > 7) || (a < -8);
         end
         3'd1, 3'd6, 3'd7: begin
            a   = sx - sy;
            r.c = (x >= y);
            r.v = (a > 7) || (a < -8);
            if (op == 3'd1)      r.s = 4'(x - y);
            else if (op == 3'd6) r.s = {3'b000, (sx < sy)};
            else                 r.s = {3'b000, (x == y)};
         end
         3'd2:    r.s = ~x;
         3'd3:    r.s = x & y;
         3'd4:    r.s = x | y;
         default: r.s = x ^ y;
      endcase
      r.z = (r.s == 4'h0);
      return r;
   endfunction

   function automatic logic exp_gnt(input logic [1:0] v);
`ifdef ALU_ARB_FIXED_PRIORITY_EN
      return ~v[0];
`else
      return (&v) ? ~m_last : v[1];
`endif
   endfunction

   function automatic rsp_t observed();
      return {rsp_id, rsp_s, rsp_c, rsp_zero, rsp_overflow};
   endfunction

   function automatic logic [1:0] onehot(input logic g);
      return g ? 2'b10 : 2'b01;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic [1:0] v, input logic [5:0] op, input logic [7:0] x, input logic [7:0] y);
      req_valid = v;
      req_op    = op;
      req_x     = x;
      req_y     = y;
   endtask

   task automatic rand_req(input logic [1:0] v);
      set_req(v, 6'($urandom), 8'($urandom), 8'($urandom));
   endtask

   task automatic commit(input logic g);
      tick();
      m_last = g;
   endtask

   // Cycles counted from the transfer cycle; the cycle after the transfer is 1.
   task automatic wait_rsp(output int lat);
      lat = 1;
      while (rsp_valid !== 1'b1 && lat < 10) begin
         tick();
         lat++;
      end
   endtask

   task automatic test_reset();
      logic [1:0] vin[3];
      logic [1:0] vexp[3];
      vin  = '{2'b01, 2'b10, 2'b11};
      vexp = '{2'b01, 2'b10, 2'b01};
      rst = 1'b1;
      set_req(2'b00, 6'h0, 8'h0, 8'h0);
      rsp_ready = 1'b0;
      tick();
      tick();
      n_vec++;
      if ({rsp_valid, observed()} !== 9'h0) begin
         n_err++;
         $display("FAIL reset_outputs: got %h want %h", {rsp_valid, observed()}, 9'h0);
      end
      n_vec++;
      if (req_ready !== 2'b00) begin
         n_err++;
         $display("FAIL reset_ready: got %b want 00", req_ready);
      end
      rst = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
         req_valid = vin[i];
         #1;
         n_vec++;
         if (req_ready !== vexp[i]) begin
            n_err++;
            $display("FAIL reset_grant[%0d]: got %b want %b", i, req_ready, vexp[i]);
         end
      end
      req_valid = 2'b00;
   endtask

   task automatic test_ops();
      rsp_t       dir_exp[3];
      logic       d_id[3];
      logic [2:0] d_op[3];
      logic [3:0] d_x[3];
      logic [3:0] d_y[3];
      dir_exp[0] = {1'b0, 4'h8, 3'b001};
      dir_exp[1] = {1'b1, 4'h0, 3'b110};
      dir_exp[2] = {1'b0, 4'h1, 3'b100};
      d_id = '{1'b0, 1'b1, 1'b0};
      d_op = '{3'b000, 3'b001, 3'b110};
      d_x  = '{4'h7, 4'h3, 4'hE};
      d_y  = '{4'h1, 4'h3, 4'h1};
      rsp_ready = 1'b1;
      for (int n = 0; n < 11; n++) begin
         logic       id;
         logic [2:0] o;
         logic [3:0] x;
         logic [3:0] y;
         logic [1:0] v;
         int         lat;
         rsp_t       e;
         rsp_t       got;
         if (n < 3) begin
            id = d_id[n]; o = d_op[n]; x = d_x[n]; y = d_y[n];
         end else begin
            id = 1'(n & 1); o = 3'(n - 3); x = 4'($urandom); y = 4'($urandom);
         end
         v = onehot(id);
         set_req(v, id ? {o, 3'($urandom)} : {3'($urandom), o},
                    id ? {x, 4'($urandom)} : {4'($urandom), x},
                    id ? {y, 4'($urandom)} : {4'($urandom), y});
         sb.push_back((n < 3) ? dir_exp[n] : model(id, o, x, y));
         #1;
         n_vec++;
         if (req_ready !== v) begin
            n_err++;
            $display("FAIL ops_grant[%0d]: got %b want %b", n, req_ready, v);
         end
         commit(id);
         req_valid = 2'b00;
         n_vec++;
         if ({rsp_valid, req_ready} !== 3'b000) begin
            n_err++;
            $display("FAIL ops_exec[%0d]: got valid/ready %b want 000", n, {rsp_valid, req_ready});
         end
         wait_rsp(lat);
         n_vec++;
         if (lat !== 2) begin
            n_err++;
            $display("FAIL ops_latency[%0d]: got %0d want 2", n, lat);
         end
         e   = sb.pop_front();
         got = observed();
         n_vec++;
         if (got !== e) begin
            n_err++;
            $display("FAIL ops_result[%0d] op=%0d x=%h y=%h: got id/s/c/z/v %h want %h", n, o, x, y, got, e);
         end
         tick();
         n_vec++;
         if (rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL ops_done[%0d]: got rsp_valid %b want 0", n, rsp_valid);
         end
      end
   endtask

   task automatic test_contention();
      logic order[4];
`ifdef ALU_ARB_FIXED_PRIORITY_EN
      order = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
      order = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_last = 1'b1;
      sb.delete();
      rsp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         logic [5:0] op;
         logic [7:0] x;
         logic [7:0] y;
         logic       g;
         int         lat;
         rsp_t       e;
         rsp_t       got;
         op = 6'($urandom); x = 8'($urandom); y = 8'($urandom);
         set_req(2'b11, op, x, y);
         g = exp_gnt(2'b11);
         sb.push_back(model(g, g ? op[5:3] : op[2:0], g ? x[7:4] : x[3:0], g ? y[7:4] : y[3:0]));
         #1;
         n_vec++;
         if (req_ready !== onehot(order[k])) begin
            n_err++;
            $display("FAIL contend_grant[%0d]: got %b want %b", k, req_ready, onehot(order[k]));
         end
         commit(g);
         n_vec++;
         if (req_ready !== 2'b00) begin
            n_err++;
            $display("FAIL contend_exec_ready[%0d]: got %b want 00", k, req_ready);
         end
         wait_rsp(lat);
         n_vec++;
         if (lat !== 2) begin
            n_err++;
            $display("FAIL contend_latency[%0d]: got %0d want 2", k, lat);
         end
         e   = sb.pop_front();
         got = observed();
         n_vec++;
         if (got !== e) begin
            n_err++;
            $display("FAIL contend_result[%0d]: got %h want %h", k, got, e);
         end
         tick();
      end
      req_valid = 2'b00;
   endtask

   task automatic test_backpressure();
      logic [5:0] op;
      logic [7:0] x;
      logic [7:0] y;
      int         lat;
      rsp_t       e;
      rsp_ready = 1'b0;
      op = 6'($urandom); x = 8'($urandom); y = 8'($urandom);
      set_req(2'b01, op, x, y);
      sb.push_back(model(1'b0, op[2:0], x[3:0], y[3:0]));
      #1;
      n_vec++;
      if (req_ready !== 2'b01) begin
         n_err++;
         $display("FAIL bp_grant: got %b want 01", req_ready);
      end
      commit(1'b0);
      wait_rsp(lat);
      e = sb.pop_front();
      for (int i = 0; i < 5; i++) begin
         rand_req(2'b11);
         #1;
         n_vec++;
         if (observed() !== e || {rsp_valid, req_ready} !== 3'b100) begin
            n_err++;
            $display("FAIL bp_hold[%0d]: got rsp %h valid/ready %b want rsp %h valid/ready 100",
                     i, observed(), {rsp_valid, req_ready}, e);
         end
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      n_vec++;
      if ({rsp_valid, req_ready} !== {1'b0, onehot(exp_gnt(2'b11))}) begin
         n_err++;
         $display("FAIL bp_release: got valid/ready %b want %b", {rsp_valid, req_ready},
                  {1'b0, onehot(exp_gnt(2'b11))});
      end
      req_valid = 2'b00;
   endtask

   task automatic test_reset_mid();
      for (int ph = 0; ph < 2; ph++) begin
         int lat;
         rsp_ready = 1'b0;
         rand_req(2'b01);
         #1;
         commit(1'b0);
         req_valid = 2'b11;
         if (ph == 1) begin
            wait_rsp(lat);
            n_vec++;
            if (rsp_valid !== 1'b1) begin
               n_err++;
               $display("FAIL rm_reach_resp: got rsp_valid %b want 1", rsp_valid);
            end
         end
         rst = 1'b1;
         tick();
         rst = 1'b0;
         m_last = 1'b1;
         sb.delete();
         n_vec++;
         if ({rsp_valid, observed()} !== 9'h0) begin
            n_err++;
            $display("FAIL rm_cleared[%0d]: got %h want %h", ph, {rsp_valid, observed()}, 9'h0);
         end
         n_vec++;
         if (req_ready !== 2'b01) begin
            n_err++;
            $display("FAIL rm_grant[%0d]: got %b want 01", ph, req_ready);
         end
         req_valid = 2'b00;
      end
      rsp_ready = 1'b1;
   endtask

   initial begin
      test_reset();
      test_ops();
      test_contention();
      test_backpressure();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
